decap_meta_trim: RTL and testbench

Post-decapsulation tail fix-up stage placed directly downstream of the header decapsulation stage on the meta stream. After decap has shifted meta left by D shift units from the decap slice onward, the packet is D units shorter. This block rewrites each slice's valid-unit count and moves the TAIL tag. When the last slice becomes empty, it drops that slice and marks the preceding slice as the tail. It is a fixed-latency pipeline with no backpressure, matching the rest of the parser datapath.

---
 rtl/decap_meta_trim.sv | 140 ++++++++++++++
 tb/tb_decap_meta_trim.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/decap_meta_trim.sv
// Post-decap tail fix-up. Rewrites per-slice CNT/TAIL after decap shortens a packet by D units
// and drops a trailing slice that became empty. The latency is fixed at 2 cycles.
module decap_meta_trim #(
    parameter int unsigned META_W = 512,
    parameter int unsigned UNIT_W = 8,
    parameter int unsigned TAG_W  = 16,
    parameter int unsigned DLEN_W = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [META_W+TAG_W-1:0]  i_meta,
    input  logic [DLEN_W-1:0]        i_decapLength,
    input  logic                     i_decapEn,
    output logic [META_W+TAG_W-1:0]  o_meta,
    output logic [15:0]              o_pktLen,
    output logic [31:0]              o_dropCnt,
    output logic                     o_err
);

    localparam int unsigned NumUnits = META_W / UNIT_W;
    localparam int unsigned SliceW   = META_W + TAG_W;
    localparam int unsigned BitStart = META_W;
    localparam int unsigned BitValid = META_W + 1;
    localparam int unsigned BitTail  = META_W + 2;
    localparam int unsigned CntLo    = META_W + 8;
    localparam int unsigned CntHi    = META_W + 15;
    localparam logic [7:0]  NumCnt   = 8'(NumUnits);

    typedef enum logic [0:0] {StIdle, StBody} state_e;

    state_e              state_q, state_d;
    logic [SliceW-1:0]   s1_q, out_q, emit;
    logic [DLEN_W-1:0]   d_s1_q, d_pkt_q, s0_d;
    logic [15:0]         pkt_len_q, acc_q, acc_sum;
    logic [31:0]         drop_cnt_q;
    logic                err_q, emit_err, emit_drop, force_tail;

    logic       s0_valid, s0_start, s0_tail;
    logic [7:0] s0_cnt, s0_dc;
    logic       s1_valid, s1_start, s1_tail;
    logic [7:0] s1_cnt, s1_dc;

    assign s0_valid = i_meta[BitValid];
    assign s0_start = i_meta[BitStart];
    assign s0_tail  = i_meta[BitTail];
    assign s0_cnt   = i_meta[CntHi:CntLo];
    assign s1_valid = s1_q[BitValid];
    assign s1_start = s1_q[BitStart];
    assign s1_tail  = s1_q[BitTail];
    assign s1_cnt   = s1_q[CntHi:CntLo];

    // Look-ahead slice uses its own D: a new START carries the next packet's decap length.
    assign s0_d  = (s0_valid && s0_start) ? (i_decapEn ? i_decapLength : '0) : d_pkt_q;
    assign s0_dc = 8'(s0_d);
    assign s1_dc = 8'(d_s1_q);

    // FSM tracks the packet state of the input (S0) stream.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (s0_valid && s0_start && !s0_tail) state_d = StBody;
            StBody: if (!s0_valid || s0_tail) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        force_tail = (state_q == StBody) && (!s0_valid || s0_start);
    end

    always_comb begin
        emit      = s1_q;
        emit_drop = 1'b0;
        emit_err  = 1'b0;
        if (!s1_valid) begin
            emit = '0;
        end else if (s1_tail) begin
            if (s1_cnt > s1_dc) begin
                emit[CntHi:CntLo] = s1_cnt - s1_dc;
            end else if (!s1_start) begin
                emit      = '0;
                emit_drop = 1'b1;
            end else begin
                emit[CntHi:CntLo] = 8'd0;
                emit[BitStart]    = 1'b1;
                emit[BitValid]    = 1'b1;
                emit[BitTail]     = 1'b1;
                emit_err          = 1'b1;
            end
        end else if (force_tail) begin
            emit[BitTail] = 1'b1;
            emit_err      = 1'b1;
        end else if (s0_valid && !s0_start && s0_tail && (s0_cnt <= s0_dc)) begin
            // Next slice will be dropped, so this one becomes the tail.
            emit[CntHi:CntLo] = NumCnt - (s0_dc - s0_cnt);
            emit[BitTail]     = 1'b1;
        end
    end

    assign acc_sum = emit[BitStart] ? 16'(emit[CntHi:CntLo])
                                    : acc_q + 16'(emit[CntHi:CntLo]);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q       <= '0;
            d_s1_q     <= '0;
            d_pkt_q    <= '0;
            out_q      <= '0;
            pkt_len_q  <= '0;
            acc_q      <= '0;
            drop_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            s1_q   <= i_meta;
            d_s1_q <= s0_d;
            if (s0_valid && s0_start) d_pkt_q <= s0_d;
            out_q  <= emit;
            err_q  <= emit_err;
            if (emit_drop) drop_cnt_q <= drop_cnt_q + 32'd1;
            if (emit[BitValid]) begin
                acc_q <= acc_sum;
                if (emit[BitTail]) pkt_len_q <= acc_sum;
            end
        end
    end

    assign o_meta    = out_q;
    assign o_pktLen  = pkt_len_q;
    assign o_dropCnt = drop_cnt_q;
    assign o_err     = err_q;

endmodule

// File: tb/tb_decap_meta_trim.sv
// Directed bench for decap_meta_trim: each task drives a short slice sequence and checks the
// trimmed output, packet length, drop count and error pulse against hand-computed values.
module tb_decap_meta_trim;

    localparam int W = 528;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  meta_in;
    logic [5:0]    dlen;
    logic          den;
    logic [W-1:0]  o_meta;
    logic [15:0]   o_pktLen;
    logic [31:0]   o_dropCnt;
    logic          o_err;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] vin[16];
    logic [5:0]   vd[16];
    logic         ven[16];
    logic [W-1:0] obs_meta[16];
    logic [15:0]  obs_len[16];
    logic [31:0]  obs_drop[16];
    logic         obs_err[16];
    logic [W-1:0] ex[16];

    always #5 clk = ~clk;

    decap_meta_trim dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_meta        (meta_in),
        .i_decapLength (dlen),
        .i_decapEn     (den),
        .o_meta        (o_meta),
        .o_pktLen      (o_pktLen),
        .o_dropCnt     (o_dropCnt),
        .o_err         (o_err)
    );

    function automatic logic [W-1:0] mk(input logic s, input logic v, input logic t,
                                        input logic [7:0] cnt, input logic [31:0] seed);
        logic [15:0] tag;
        tag = {cnt, 5'b0, t, v, s};
        return {tag, {16{seed}}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives vin[0..n-1] then idles; obs[k] holds the output produced for vin[k].
    task automatic run_seq(input int n);
        for (int i = 0; i < n + 2; i++) begin
            if (i < n) begin
                meta_in = vin[i]; dlen = vd[i]; den = ven[i];
            end else begin
                meta_in = '0; dlen = '0; den = 1'b0;
            end
            step();
            if (i >= 1) begin
                obs_meta[i-1] = o_meta;
                obs_len[i-1]  = o_pktLen;
                obs_drop[i-1] = o_dropCnt;
                obs_err[i-1]  = o_err;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; meta_in = mk(1, 1, 1, 8'd9, 32'hdeadbeef); dlen = 6'd3; den = 1'b1;
        step(); step(); step();
        checks++; if (o_meta !== '0) begin errors++; $display("FAIL reset_meta got %h exp 0", o_meta); end
        checks++; if (o_pktLen !== 16'd0) begin errors++; $display("FAIL reset_len got %0d exp 0", o_pktLen); end
        checks++; if (o_dropCnt !== 32'd0) begin errors++; $display("FAIL reset_drop got %0d exp 0", o_dropCnt); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b exp 0", o_err); end
        rst = 1'b0; meta_in = '0; dlen = '0; den = 1'b0;
        step(); step();
    endtask

    task automatic test_single();
        vin[0] = mk(1, 1, 1, 8'd40, 32'h11111111); vd[0] = 6'd10; ven[0] = 1'b1;
        run_seq(1);
        checks++; if (obs_meta[0] !== mk(1, 1, 1, 8'd30, 32'h11111111)) begin errors++;
            $display("FAIL single_meta got %h exp cnt30", obs_meta[0]); end
        checks++; if (obs_len[0] !== 16'd30) begin errors++; $display("FAIL single_len got %0d exp 30", obs_len[0]); end
        checks++; if (obs_err[0] !== 1'b0) begin errors++; $display("FAIL single_err got %b exp 0", obs_err[0]); end
        checks++; if (obs_meta[1] !== '0) begin errors++; $display("FAIL single_idle got %h exp 0", obs_meta[1]); end
    endtask

    task automatic test_multi();
        vin[0] = mk(1, 1, 0, 8'd64, 32'h22220000); vd[0] = 6'd10; ven[0] = 1'b1;
        vin[1] = mk(0, 1, 0, 8'd64, 32'h22221111); vd[1] = 6'd0;  ven[1] = 1'b0;
        vin[2] = mk(0, 1, 1, 8'd20, 32'h22222222); vd[2] = 6'd0;  ven[2] = 1'b0;
        ex[0] = vin[0];
        ex[1] = vin[1];
        ex[2] = mk(0, 1, 1, 8'd10, 32'h22222222);
        run_seq(3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_meta[i] !== ex[i]) begin errors++;
                $display("FAIL multi_meta[%0d] got %h exp %h", i, obs_meta[i], ex[i]); end
        end
        checks++; if (obs_len[2] !== 16'd138) begin errors++; $display("FAIL multi_len got %0d exp 138", obs_len[2]); end
        checks++; if (obs_drop[2] !== 32'd0) begin errors++; $display("FAIL multi_drop got %0d exp 0", obs_drop[2]); end
    endtask

    task automatic test_drop(input logic with_next);
        vin[0] = mk(1, 1, 0, 8'd64, 32'h33330000); vd[0] = 6'd10; ven[0] = 1'b1;
        vin[1] = mk(0, 1, 0, 8'd64, 32'h33331111); vd[1] = 6'd0;  ven[1] = 1'b0;
        vin[2] = mk(0, 1, 1, 8'd6,  32'h33332222); vd[2] = 6'd0;  ven[2] = 1'b0;
        vin[3] = mk(1, 1, 1, 8'd50, 32'h44440000); vd[3] = 6'd0;  ven[3] = 1'b1;
        ex[0] = vin[0];
        ex[1] = mk(0, 1, 1, 8'd60, 32'h33331111);
        ex[2] = '0;
        ex[3] = vin[3];
        run_seq(with_next ? 4 : 3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_meta[i] !== ex[i]) begin errors++;
                $display("FAIL drop_meta[%0d] got %h exp %h", i, obs_meta[i], ex[i]); end
        end
        checks++; if (obs_len[1] !== 16'd124) begin errors++; $display("FAIL drop_len got %0d exp 124", obs_len[1]); end
        checks++; if (obs_drop[1] !== (with_next ? 32'd1 : 32'd0)) begin errors++;
            $display("FAIL drop_cnt_before got %0d", obs_drop[1]); end
        checks++; if (obs_drop[2] !== (with_next ? 32'd2 : 32'd1)) begin errors++;
            $display("FAIL drop_cnt got %0d", obs_drop[2]); end
        if (with_next) begin
            checks++; if (obs_meta[3] !== ex[3]) begin errors++;
                $display("FAIL b2b_meta got %h exp %h", obs_meta[3], ex[3]); end
            checks++; if (obs_len[3] !== 16'd50) begin errors++; $display("FAIL b2b_len got %0d exp 50", obs_len[3]); end
            checks++; if (obs_err[3] !== 1'b0) begin errors++; $display("FAIL b2b_err got %b exp 0", obs_err[3]); end
        end
    endtask

    task automatic test_passthrough();
        vin[0] = mk(1, 1, 0, 8'd64, 32'h55550000); vd[0] = 6'd20; ven[0] = 1'b0;
        vin[1] = mk(0, 1, 1, 8'd5,  32'h55551111); vd[1] = 6'd20; ven[1] = 1'b0;
        vin[2] = mk(1, 1, 1, 8'd5,  32'h55552222); vd[2] = 6'd20; ven[2] = 1'b0;
        run_seq(3);
        for (int i = 0; i < 3; i++) begin
            checks++; if (obs_meta[i] !== vin[i]) begin errors++;
                $display("FAIL pass_meta[%0d] got %h exp %h", i, obs_meta[i], vin[i]); end
        end
        checks++; if (obs_len[1] !== 16'd69) begin errors++; $display("FAIL pass_len1 got %0d exp 69", obs_len[1]); end
        checks++; if (obs_len[2] !== 16'd5) begin errors++; $display("FAIL pass_len2 got %0d exp 5", obs_len[2]); end
        checks++; if (obs_drop[2] !== 32'd2) begin errors++; $display("FAIL pass_drop got %0d exp 2", obs_drop[2]); end
    endtask

    task automatic test_violations();
        logic ee[5];
        vin[0] = mk(1, 1, 0, 8'd64, 32'h66660000); vd[0] = 6'd0;  ven[0] = 1'b1;
        vin[1] = mk(1, 1, 1, 8'd30, 32'h66661111); vd[1] = 6'd0;  ven[1] = 1'b1;
        vin[2] = mk(1, 1, 1, 8'd5,  32'h66662222); vd[2] = 6'd10; ven[2] = 1'b1;
        vin[3] = mk(1, 1, 0, 8'd64, 32'h66663333); vd[3] = 6'd0;  ven[3] = 1'b1;
        vin[4] = '0;                                vd[4] = 6'd0;  ven[4] = 1'b0;
        ex[0] = mk(1, 1, 1, 8'd64, 32'h66660000); ee[0] = 1'b1;
        ex[1] = vin[1];                           ee[1] = 1'b0;
        ex[2] = mk(1, 1, 1, 8'd0,  32'h66662222); ee[2] = 1'b1;
        ex[3] = mk(1, 1, 1, 8'd64, 32'h66663333); ee[3] = 1'b1;
        ex[4] = '0;                               ee[4] = 1'b0;
        run_seq(5);
        for (int i = 0; i < 5; i++) begin
            checks++; if (obs_meta[i] !== ex[i]) begin errors++;
                $display("FAIL viol_meta[%0d] got %h exp %h", i, obs_meta[i], ex[i]); end
            checks++; if (obs_err[i] !== ee[i]) begin errors++;
                $display("FAIL viol_err[%0d] got %b exp %b", i, obs_err[i], ee[i]); end
        end
        checks++; if (obs_len[0] !== 16'd64) begin errors++; $display("FAIL viol_len0 got %0d exp 64", obs_len[0]); end
        checks++; if (obs_len[2] !== 16'd0) begin errors++; $display("FAIL viol_len2 got %0d exp 0", obs_len[2]); end
        checks++; if (obs_drop[4] !== 32'd2) begin errors++; $display("FAIL viol_drop got %0d exp 2", obs_drop[4]); end
    endtask

    task automatic test_reset_mid();
        meta_in = mk(1, 1, 0, 8'd64, 32'h77770000); dlen = 6'd10; den = 1'b1;
        step();
        meta_in = mk(0, 1, 0, 8'd64, 32'h77771111); dlen = 6'd0; den = 1'b0;
        step();
        rst = 1'b1; meta_in = mk(0, 1, 1, 8'd20, 32'h77772222);
        step();
        checks++; if (o_meta !== '0) begin errors++; $display("FAIL rmid_meta got %h exp 0", o_meta); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL rmid_err got %b exp 0", o_err); end
        checks++; if (o_dropCnt !== 32'd0) begin errors++; $display("FAIL rmid_drop got %0d exp 0", o_dropCnt); end
        checks++; if (o_pktLen !== 16'd0) begin errors++; $display("FAIL rmid_len got %0d exp 0", o_pktLen); end
        rst = 1'b0; meta_in = '0;
        step();
        checks++; if (o_meta !== '0) begin errors++; $display("FAIL rmid_stale got %h exp 0", o_meta); end
        vin[0] = mk(1, 1, 1, 8'd40, 32'h88880000); vd[0] = 6'd10; ven[0] = 1'b1;
        run_seq(1);
        checks++; if (obs_meta[0] !== mk(1, 1, 1, 8'd30, 32'h88880000)) begin errors++;
            $display("FAIL rmid_next got %h exp cnt30", obs_meta[0]); end
        checks++; if (obs_len[0] !== 16'd30) begin errors++; $display("FAIL rmid_next_len got %0d exp 30", obs_len[0]); end
        checks++; if (obs_err[0] !== 1'b0 || obs_err[1] !== 1'b0) begin errors++;
            $display("FAIL rmid_next_err got %b%b exp 00", obs_err[0], obs_err[1]); end
        checks++; if (obs_meta[1] !== '0) begin errors++; $display("FAIL rmid_tail got %h exp 0", obs_meta[1]); end
    endtask

    initial begin
        rst = 1'b1; meta_in = '0; dlen = '0; den = 1'b0;
        test_reset();
        test_single();
        test_multi();
        test_drop(1'b0);
        test_drop(1'b1);
        test_passthrough();
        test_violations();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
